sram_rd_streamer: RTL and testbench
===================================

# sram_rd_streamer

Read-side sequencer that sits directly upstream of the banked dual-port SRAM array and drives its port B. It accepts a burst command (base address, word count) and issues one read per cycle on the array's read port, tracking the array's one-cycle read latency. A 2-entry output buffer absorbs that latency, and returned words are delivered on a valid/ready stream with a last marker. Downstream consumers are the packet egress logic.

## Interface
Parameters:
- DWIDTH, 32, data word width; matches the SRAM array.
- NRAMWIDHT, 5, bank-select address bits; the array has 2^NRAMWIDHT banks.
- AWIDTH, 13, in-bank word offset bits.
- LWIDTH, 12, burst length field width.

Ports (clock and reset first):
- clk_in  input  1  single clock for the whole block.
- rst_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  burst command strobe; sampled only in IDLE.
- base_addr_in  input  NRAMWIDHT+AWIDTH  first word address, {bank, offset}.
- len_in  input  LWIDTH  burst length minus one (0 means 1 word, max 2^LWIDTH words).
- busy_out  output  1  high from the cycle after start is accepted until done.
- done_out  output  1  one-cycle pulse the cycle after the last word handshake.
- sram_en_out  output  1  port B enable to the array.
- sram_we_out  output  1  port B write enable; constant 0.
- sram_addr_out  output  NRAMWIDHT+AWIDTH  port B address.
- sram_d_in  input  DWIDTH  port B read data; valid one cycle after sram_en_out.
- data_out  output  DWIDTH  stream data (buffer head).
- valid_out  output  1  stream valid.
- last_out  output  1  qualifies data_out as the final word of the burst.
- ready_in  input  1  stream ready from the consumer.

## Operation
- FSM states and transitions:
  - IDLE: start_in=1 latches base_addr_in into the address register and len_in into the remaining counter, then goes to RUN.
  - RUN: issues reads. After the read whose remaining count is 0, goes to DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty, then goes to IDLE and pulses done_out.
- start_in outside IDLE is ignored; it is neither queued nor an error.
- Issue rule:
  - Occupancy = buffer entries + in-flight read (0 or 1).
  - In RUN, a read is issued when occupancy ≤1, or when occupancy is 2 and a pop (valid_out & ready_in) happens this cycle.
  - The buffer therefore never overflows.
- Each issued read drives sram_en_out=1 and sram_addr_out=current address. The address then increments and the remaining count decrements.
- Return path: an in-flight flag is set when a read issues. On the next cycle sram_d_in is written into the buffer with a last bit attached. The last bit is set when that read was the final one.
- Buffer: 2-entry FIFO. Push and pop in the same cycle are both allowed. data_out, valid_out and last_out come from the head entry.
- Address increment is modulo 2^(NRAMWIDHT+AWIDTH): 0x3FFFF wraps to 0x00000 and carries across banks (see Configuration).
- Counter width is LWIDTH. The remaining count never underflows, because RUN exits when it reaches 0.

## Timing
- Reset values of outputs:
  - busy_out=0, done_out=0
  - sram_en_out=0, sram_we_out=0, sram_addr_out=0
  - valid_out=0, last_out=0, data_out=0
- Reset also sets FSM=IDLE, clears the buffer and clears the in-flight flag.
- Latency, start_in sampled at edge 0:
  - busy_out=1 and the first sram_en_out in cycle 1.
  - Data is captured at edge 3; valid_out=1 in cycle 3.
- Throughput: 1 word/cycle while ready_in=1.
- Backpressure: ready_in held low stalls issue after at most 2 words are buffered. Buffered data is held stable while valid_out=1 and ready_in=0.
- Done: done_out pulses in the cycle after the handshake with last_out=1. busy_out falls in the same cycle, and a new start_in is accepted in that cycle.
- Reset asserted mid-burst aborts immediately. No done_out pulse is produced, and buffered data is discarded.

## Configuration
- SRAM_RD_BANK_WRAP_EN defined: the increment only affects the AWIDTH offset bits, and the bank bits stay fixed for the whole burst. Example: bank 3 offset 0x1FFF is followed by bank 3 offset 0x0000.
- SRAM_RD_BANK_WRAP_EN undefined: the full NRAMWIDHT+AWIDTH increment applies, so offset overflow carries into the bank bits.

## Structure
- Shared package sram_pkg holds:
  - the address-width constants;
  - a typedef for the {bank, offset} address struct;
  - the FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, sram_rd_skid_fifo: the 2-entry buffer with count, push/pop, and a data+last payload.

## Test plan
- Single word: base 0x02000, len 0, ready high -> one sram_en at cycle 1 with addr 0x02000; valid with last=1 at cycle 3; done_out at cycle 4.
- Full-rate burst: base 0x00010, len 7, ready high -> 8 consecutive reads at 0x00010–0x00017; 8 back-to-back valid words with last on the 8th, in the same order.
- Backpressure: len 15, ready toggling 1-0-0-1 -> no word lost or duplicated; buffer count never exceeds 2; data stable while stalled.
- Wrap: base 0x01FFE, len 3 -> addresses 01FFE, 01FFF, 02000, 02001 without the macro; 01FFE, 01FFF, 00000, 00001 with SRAM_RD_BANK_WRAP_EN.
- Ignored start: pulse start_in mid-burst with other parameters -> the burst continues unchanged and there is no second done.
- Reset mid-burst: assert rst_n_in at word 3 of 10 -> all outputs return to reset values at once; the next start runs cleanly from its new base.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, address struct and FSM state for the SRAM read streamer
package sram_pkg;

    localparam int SRAM_DWIDTH    = 32;
    localparam int SRAM_NRAMWIDHT = 5;
    localparam int SRAM_AWIDTH    = 13;
    localparam int SRAM_LWIDTH    = 12;

    typedef struct packed {
        logic [SRAM_NRAMWIDHT-1:0] bank;
        logic [SRAM_AWIDTH-1:0]    offset;
    } sram_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sram_rd_state_e;

endpackage

// File: rtl/sram_rd_skid_fifo.sv
// rtl/sram_rd_skid_fifo.sv - 2-entry FIFO holding {last, data} returned from the SRAM
// Ports: clk_i, rst_ni (async active-low); push_i/data_i/last_i write side;
//        pop_i read side; data_o/last_o/valid_o show the head entry; count_o = occupancy.
module sram_rd_skid_fifo #(
    parameter int DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              last_i,
    input  logic              pop_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              last_o,
    output logic              valid_o,
    output logic [1:0]        count_o
);

    logic [DWIDTH:0] mem_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {last_i, data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign {last_o, data_o} = mem_q[rd_ptr_q];
    assign valid_o          = (count_q != 2'd0);
    assign count_o          = count_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// rtl/sram_rd_streamer.sv - burst read sequencer for SRAM port B with a valid/ready output stream
// Ports: clk_in, rst_n_in (async active-low); start_in/base_addr_in/len_in burst command;
//        busy_out/done_out status; sram_en_out/sram_we_out/sram_addr_out/sram_d_in array port B;
//        data_out/valid_out/last_out/ready_in output stream.
// Optional build macro: SRAM_RD_BANK_WRAP_EN keeps the bank bits fixed and wraps only the offset.
module sram_rd_streamer
    import sram_pkg::*;
#(
    parameter int DWIDTH    = SRAM_DWIDTH,
    parameter int NRAMWIDHT = SRAM_NRAMWIDHT,
    parameter int AWIDTH    = SRAM_AWIDTH,
    parameter int LWIDTH    = SRAM_LWIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [NRAMWIDHT+AWIDTH-1:0] base_addr_in,
    input  logic [LWIDTH-1:0]         len_in,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      sram_en_out,
    output logic                      sram_we_out,
    output logic [NRAMWIDHT+AWIDTH-1:0] sram_addr_out,
    input  logic [DWIDTH-1:0]         sram_d_in,
    output logic [DWIDTH-1:0]         data_out,
    output logic                      valid_out,
    output logic                      last_out,
    input  logic                      ready_in
);

    localparam int ADDR_W = NRAMWIDHT + AWIDTH;

    sram_rd_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [LWIDTH-1:0] rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;
    logic              issue;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [1:0]        occ;

`ifdef SRAM_RD_BANK_WRAP_EN
    assign addr_inc = {addr_q[ADDR_W-1:AWIDTH], addr_q[AWIDTH-1:0] + AWIDTH'(1)};
`else
    assign addr_inc = addr_q + ADDR_W'(1);
`endif

    assign pop = valid_out & ready_in;
    // Buffered words plus the read still in flight; can never exceed 2.
    assign occ = fifo_count + {1'b0, inflight_q};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        issue           = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    addr_d  = base_addr_in;
                    rem_d   = len_in;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A slot frees this cycle if the consumer pops, so a full pipe may still issue.
                issue = (occ <= 2'd1) || ((occ == 2'd2) && pop);
                if (issue) begin
                    addr_d          = addr_inc;
                    inflight_d      = 1'b1;
                    inflight_last_d = (rem_q == '0);
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        rem_d = rem_q - LWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // The final word is the only one carrying last, so its handshake ends the burst.
                if (pop && last_out) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    sram_rd_skid_fifo #(
        .DWIDTH (DWIDTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .push_i  (inflight_q),
        .data_i  (sram_d_in),
        .last_i  (inflight_last_q),
        .pop_i   (pop),
        .data_o  (data_out),
        .last_o  (last_out),
        .valid_o (valid_out),
        .count_o (fifo_count)
    );

    assign busy_out      = (state_q != IDLE);
    assign done_out      = done_q;
    assign sram_en_out   = issue;
    assign sram_we_out   = 1'b0;
    assign sram_addr_out = addr_q;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb/tb_sram_rd_streamer.sv - randomized self-checking bench for sram_rd_streamer
module tb_sram_rd_streamer;
    import sram_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic [17:0] base_addr_in;
    logic [11:0] len_in;
    logic        busy_out, done_out;
    logic        sram_en_out, sram_we_out;
    logic [17:0] sram_addr_out;
    logic [31:0] sram_d_in;
    logic [31:0] data_out;
    logic        valid_out, last_out;
    logic        ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];

    always #5 clk_in = ~clk_in;

    sram_rd_streamer dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .start_in      (start_in),
        .base_addr_in  (base_addr_in),
        .len_in        (len_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .sram_en_out   (sram_en_out),
        .sram_we_out   (sram_we_out),
        .sram_addr_out (sram_addr_out),
        .sram_d_in     (sram_d_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .last_out      (last_out),
        .ready_in      (ready_in)
    );

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return {a[13:0] ^ 14'h2A5, a};
    endfunction

    function automatic logic [17:0] next_addr(input logic [17:0] a);
        sram_addr_t s;
        s = a;
`ifdef SRAM_RD_BANK_WRAP_EN
        s.offset = s.offset + 13'd1;
        return s;
`else
        return a + 18'd1;
`endif
    endfunction

    // SRAM array model: one-cycle read latency
    always @(posedge clk_in) begin
        if (sram_en_out) sram_d_in <= mem_word(sram_addr_out);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_en", sram_en_out, 0);
        check("rst_we", sram_we_out, 0);
        check("rst_addr", sram_addr_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_data", data_out, 0);
    endtask

    function automatic logic ready_pick(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 4 == 0) || (cyc % 4 == 1);
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    // mode: 0 ready high, 1 ready 1-0-0-1, 2 random ready, 3 ready high + stray starts
    // rst_word > 0: assert reset right after that many words were delivered
    task automatic run_burst(input logic [17:0] base, input int len, input int mode, input int rst_word);
        logic [17:0] a;
        logic [31:0] held;
        int cyc, issued, popped;
        bit done_seen, aborted, stall_q;
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        a = base;
        for (int i = 0; i <= len; i++) begin
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
            exp_last.push_back(i == len);
            a = next_addr(a);
        end
        @(negedge clk_in);
        start_in = 1'b1; base_addr_in = base; len_in = 12'(len); ready_in = 1'b1;
        #1 check("idle_before_start", busy_out, 0);
        @(negedge clk_in);
        start_in = 1'b0;
        cyc = 1; issued = 0; popped = 0; done_seen = 0; aborted = 0; stall_q = 0; held = '0;
        while (!done_seen && !aborted && cyc < 2000) begin
            ready_in = ready_pick(mode, cyc);
            if (mode == 3) begin
                start_in     = (cyc == 4) || (cyc == 9);
                base_addr_in = 18'($urandom);
                len_in       = 12'($urandom);
            end
            #1;
            if (popped == len + 1) begin
                check("done_pulse", done_out, 1);
                check("busy_low_at_done", busy_out, 0);
                if (mode == 0 || mode == 3) check("done_cycle", cyc, len + 4);
                done_seen = 1;
            end else begin
                check("no_early_done", done_out, 0);
                check("busy_high", busy_out, 1);
                check("we_low", sram_we_out, 0);
                check("occupancy_le2", (issued - popped) <= 2, 1);
                if (sram_en_out) begin
                    if (exp_addr.size() == 0) check("extra_read", 1, 0);
                    else check("rd_addr", sram_addr_out, exp_addr.pop_front());
                    issued++;
                end
                if (stall_q) begin
                    check("stall_valid", valid_out, 1);
                    check("stall_data", data_out, held);
                end
                if (valid_out && ready_in) begin
                    if (exp_data.size() == 0) check("extra_word", 1, 0);
                    else begin
                        check("word_data", data_out, exp_data.pop_front());
                        check("word_last", last_out, exp_last.pop_front());
                    end
                    popped++;
                end
                stall_q = valid_out && !ready_in;
                held    = data_out;
                if (rst_word > 0 && popped == rst_word) begin
                    rst_n_in = 1'b0;
                    #1 check_reset_outputs();
                    aborted = 1;
                end
            end
            @(negedge clk_in);
            if (aborted) rst_n_in = 1'b1;
            cyc++;
        end
        start_in = 1'b0;
        ready_in = 1'b1;
        if (!aborted) begin
            if (!done_seen) check("burst_timeout", 0, 1);
            check("all_reads_issued", exp_addr.size(), 0);
            for (int k = 0; k < 3; k++) begin
                #1;
                check("idle_no_done", done_out, 0);
                check("idle_not_busy", busy_out, 0);
                @(negedge clk_in);
            end
        end
    endtask

    initial begin
        rst_n_in = 1'b0; start_in = 1'b0; base_addr_in = '0; len_in = '0; ready_in = 1'b0;
        repeat (2) @(negedge clk_in);
        #1 check_reset_outputs();
        @(negedge clk_in);
        rst_n_in = 1'b1;

        run_burst(18'h02000, 0, 0, 0);
        run_burst(18'h00010, 7, 0, 0);
        run_burst(18'h00100, 15, 1, 0);
        run_burst(18'h01FFE, 3, 0, 0);
        run_burst(18'h3FFFE, 3, 0, 0);
        run_burst(18'h00500, 10, 3, 0);
        run_burst(18'h03000, 9, 0, 3);
        run_burst(18'h04000, 5, 0, 0);
        for (int r = 0; r < 6; r++) begin
            run_burst(18'($urandom), int'($urandom_range(0, 20)), 2, 0);
        end
        run_burst(18'h05FF0, 40, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
